// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with operand forwarding, single-cycle ALU,
// branch resolution, and an iterative radix-2 multiply/divide unit.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   valid_ex                  EX holds a live instruction
//   pc_ex, ru1_ex, ru2_ex,
//   ImmExt_ex                 PC, register operands, extended immediate
//   AluASrc_ex, AluBSrc_ex    A: 0=fwd rs1, 1=pc; B: 0=fwd rs2, 1=imm
//   AluOp_ex, BrOp_ex         ALU operation, branch operation
//   md_en, md_op              multiply/divide select and M-extension funct3
//   rs1_ex, rs2_ex            source register indices
//   rd_me, rd_wb,
//   RuWr_me, RuWr_wb          downstream destinations and write enables
//   alu_out_me, muxData       forwarded values from ME and WB
//   alu_out, NextPCSrc        EX result, take-branch
//   stall, result_valid       hold upstream stages, M result present
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no M operation in flight; ALU result drives alu_out
// S_BUSY | one shift/add or shift/subtract step per cycle, stall high
// S_DONE | registered M result on alu_out, result_valid high, one cycle
module ex_stage_md #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_ex,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] ru1_ex,
  input  logic [XLEN-1:0] ru2_ex,
  input  logic [XLEN-1:0] ImmExt_ex,
  input  logic            AluASrc_ex,
  input  logic            AluBSrc_ex,
  input  logic [3:0]      AluOp_ex,
  input  logic [4:0]      BrOp_ex,
  input  logic            md_en,
  input  logic [2:0]      md_op,
  input  logic [4:0]      rs1_ex,
  input  logic [4:0]      rs2_ex,
  input  logic [4:0]      rd_me,
  input  logic [4:0]      rd_wb,
  input  logic            RuWr_me,
  input  logic            RuWr_wb,
  input  logic [XLEN-1:0] alu_out_me,
  input  logic [XLEN-1:0] muxData,
  output logic [XLEN-1:0] alu_out,
  output logic            NextPCSrc,
  output logic            stall,
  output logic            result_valid
);

  // Counter must hold the value XLEN itself, hence one bit wider than SHW.
  localparam int CW = SHW + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(XLEN);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] op_a_q, op_a_d;
  logic [XLEN-1:0] op_b_q, op_b_d;
  logic [2:0]      md_op_q, md_op_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic [XLEN-1:0] res_q, res_d;

  function automatic logic a_is_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] op);
    return (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
  endfunction

  // Forwarding: ME is younger than WB, so it wins.
  logic [XLEN-1:0] fwd_a, fwd_b;

  always_comb begin
    fwd_a = ru1_ex;
    if (rs1_ex != 5'd0 && RuWr_me && rd_me == rs1_ex)      fwd_a = alu_out_me;
    else if (rs1_ex != 5'd0 && RuWr_wb && rd_wb == rs1_ex) fwd_a = muxData;
  end

  always_comb begin
    fwd_b = ru2_ex;
    if (rs2_ex != 5'd0 && RuWr_me && rd_me == rs2_ex)      fwd_b = alu_out_me;
    else if (rs2_ex != 5'd0 && RuWr_wb && rd_wb == rs2_ex) fwd_b = muxData;
  end

  logic [XLEN-1:0] alu_a, alu_b, alu_res;
  logic [SHW-1:0]  shamt;

  assign alu_a = AluASrc_ex ? pc_ex : fwd_a;
  assign alu_b = AluBSrc_ex ? ImmExt_ex : fwd_b;
  assign shamt = alu_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (AluOp_ex)
      4'b0000: alu_res = alu_a + alu_b;
      4'b1000: alu_res = alu_a - alu_b;
      4'b0001: alu_res = alu_a << shamt;
      4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      4'b0011: alu_res = {{(XLEN-1){1'b0}}, (alu_a < alu_b)};
      4'b0100: alu_res = alu_a ^ alu_b;
      4'b0101: alu_res = alu_a >> shamt;
      4'b1101: alu_res = $unsigned($signed(alu_a) >>> shamt);
      4'b0110: alu_res = alu_a | alu_b;
      4'b0111: alu_res = alu_a & alu_b;
      4'b1001: alu_res = alu_b;
      default: alu_res = '0;
    endcase
  end

  logic br_cmp, br_take;

  always_comb begin
    br_cmp = 1'b0;
    case (BrOp_ex[2:0])
      3'b000: br_cmp = (fwd_a == fwd_b);
      3'b001: br_cmp = (fwd_a != fwd_b);
      3'b100: br_cmp = ($signed(fwd_a) <  $signed(fwd_b));
      3'b101: br_cmp = ($signed(fwd_a) >= $signed(fwd_b));
      3'b110: br_cmp = (fwd_a <  fwd_b);
      3'b111: br_cmp = (fwd_a >= fwd_b);
      default: br_cmp = 1'b0;
    endcase
  end

  assign br_take = BrOp_ex[4] | (BrOp_ex[3] & br_cmp);

  // The iterative core works on magnitudes; signs are reapplied when the
  // last step completes. lo_q is loaded with |dividend| or |multiplier|.
  logic            in_neg_a;
  logic [XLEN-1:0] in_mag_a;

  assign in_neg_a = a_is_signed(md_op) & fwd_a[XLEN-1];
  assign in_mag_a = in_neg_a ? -fwd_a : fwd_a;

  logic            neg_a, neg_b, div0;
  logic [XLEN-1:0] mag_b;

  assign neg_a = a_is_signed(md_op_q) & op_a_q[XLEN-1];
  assign neg_b = b_is_signed(md_op_q) & op_b_q[XLEN-1];
  assign mag_b = neg_b ? -op_b_q : op_b_q;
  assign div0  = (op_b_q == '0);

  logic [XLEN-1:0]   mul_add, div_diff, it_hi, it_lo;
  logic [XLEN:0]     mul_sum, div_trial;
  logic              div_ge;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo, rem, md_final;

  always_comb begin
    mul_add   = lo_q[0] ? mag_b : '0;
    mul_sum   = {1'b0, hi_q} + {1'b0, mul_add};
    div_trial = {hi_q, lo_q[XLEN-1]};
    div_ge    = (div_trial >= {1'b0, mag_b});
    // When div_ge holds the true difference is below mag_b, so the
    // XLEN-bit modular subtraction is exact.
    div_diff  = div_trial[XLEN-1:0] - mag_b;
    if (md_op_q[2]) begin
      it_hi = div_ge ? div_diff : div_trial[XLEN-1:0];
      it_lo = {lo_q[XLEN-2:0], div_ge};
    end else begin
      it_hi = mul_sum[XLEN:1];
      it_lo = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  always_comb begin
    prod   = {it_hi, it_lo};
    prod_s = (neg_a ^ neg_b) ? -prod : prod;
    // Divide by zero: quotient all ones, remainder is the raw dividend.
    // min / -1 falls out naturally: |min| negated is min, remainder 0.
    quo    = div0 ? '1 : ((neg_a ^ neg_b) ? -it_lo : it_lo);
    rem    = div0 ? op_a_q : (neg_a ? -it_hi : it_hi);
    case (md_op_q)
      3'b000:                 md_final = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: md_final = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         md_final = quo;
      default:                md_final = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    md_op_d = md_op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (valid_ex && md_en) begin
          state_d = S_BUSY;
          cnt_d   = CNT_LOAD;
          op_a_d  = fwd_a;
          op_b_d  = fwd_b;
          md_op_d = md_op;
          hi_d    = '0;
          lo_d    = in_mag_a;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        hi_d  = it_hi;
        lo_d  = it_lo;
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          res_d   = md_final;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      md_op_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      md_op_q <= md_op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
    end
  end

  logic md_issue;

  assign md_issue     = (state_q == S_IDLE) && valid_ex && md_en;
  assign stall        = !rst && (md_issue || (state_q == S_BUSY));
  assign result_valid = !rst && (state_q == S_DONE);
  assign alu_out      = (state_q == S_DONE) ? res_q : alu_res;
  assign NextPCSrc    = !rst && valid_ex && !stall && br_take;

endmodule

// File: tb/tb_ex_stage_md.sv
module tb_ex_stage_md;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v32, v64, asrc, bsrc, md_en, ruwr_me, ruwr_wb;
  logic [63:0] pc, ru1, ru2, imm, alu_me, muxd;
  logic [3:0]  aluop;
  logic [4:0]  brop;
  logic [2:0]  md_op;
  logic [4:0]  rs1, rs2, rd_me, rd_wb;

  logic [31:0] out32;
  logic        npc32, stall32, rv32;
  logic [63:0] out64;
  logic        npc64, stall64, rv64;

  ex_stage_md #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .valid_ex(v32),
    .pc_ex(pc[31:0]), .ru1_ex(ru1[31:0]), .ru2_ex(ru2[31:0]), .ImmExt_ex(imm[31:0]),
    .AluASrc_ex(asrc), .AluBSrc_ex(bsrc), .AluOp_ex(aluop), .BrOp_ex(brop),
    .md_en(md_en), .md_op(md_op), .rs1_ex(rs1), .rs2_ex(rs2),
    .rd_me(rd_me), .rd_wb(rd_wb), .RuWr_me(ruwr_me), .RuWr_wb(ruwr_wb),
    .alu_out_me(alu_me[31:0]), .muxData(muxd[31:0]),
    .alu_out(out32), .NextPCSrc(npc32), .stall(stall32), .result_valid(rv32)
  );

  ex_stage_md #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .valid_ex(v64),
    .pc_ex(pc), .ru1_ex(ru1), .ru2_ex(ru2), .ImmExt_ex(imm),
    .AluASrc_ex(asrc), .AluBSrc_ex(bsrc), .AluOp_ex(aluop), .BrOp_ex(brop),
    .md_en(md_en), .md_op(md_op), .rs1_ex(rs1), .rs2_ex(rs2),
    .rd_me(rd_me), .rd_wb(rd_wb), .RuWr_me(ruwr_me), .RuWr_wb(ruwr_wb),
    .alu_out_me(alu_me), .muxData(muxd),
    .alu_out(out64), .NextPCSrc(npc64), .stall(stall64), .result_valid(rv64)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    logic [3:0]  aluop;
    logic [4:0]  brop;
    logic        valid, asrc, bsrc;
    logic [4:0]  rs1, rs2, rd_me, rd_wb;
    logic        ruwr_me, ruwr_wb;
    logic [31:0] pc, ru1, ru2, imm, me, wb;
    logic [31:0] exp_out;
    logic        exp_npc;
  } vec_t;

  vec_t tbl[$];
  vec_t v;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t base(input logic [3:0] op, input logic [4:0] br,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] e, input logic en);
    vec_t r;
    r.aluop = op; r.brop = br; r.valid = 1'b1; r.asrc = 1'b0; r.bsrc = 1'b0;
    r.rs1 = 5'd1; r.rs2 = 5'd2; r.rd_me = 5'd0; r.rd_wb = 5'd0;
    r.ruwr_me = 1'b0; r.ruwr_wb = 1'b0;
    r.pc = 32'h1000; r.ru1 = a; r.ru2 = b; r.imm = 32'h0; r.me = 32'h0; r.wb = 32'h0;
    r.exp_out = e; r.exp_npc = en;
    return r;
  endfunction

  task automatic set_defaults();
    v32 = 1'b1; v64 = 1'b0; asrc = 1'b0; bsrc = 1'b0; md_en = 1'b0; md_op = 3'd0;
    aluop = 4'd0; brop = 5'd0; pc = 64'h1000; ru1 = '0; ru2 = '0; imm = '0;
    rs1 = 5'd1; rs2 = 5'd2; rd_me = 5'd0; rd_wb = 5'd0; ruwr_me = 1'b0; ruwr_wb = 1'b0;
    alu_me = '0; muxd = '0;
  endtask

  function automatic logic cur_stall(input bit w64);
    return w64 ? stall64 : stall32;
  endfunction
  function automatic logic cur_rv(input bit w64);
    return w64 ? rv64 : rv32;
  endfunction
  function automatic logic [63:0] cur_out(input bit w64);
    return w64 ? out64 : {32'h0, out32};
  endfunction

  // Issue one M operation, scramble the forwarding sources while busy,
  // count stall cycles and compare the result against the scoreboard.
  task automatic md_run(input bit w64, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp,
                        input int exp_stall, input string name);
    int cnt;
    logic [63:0] e;
    @(posedge clk); #1;
    set_defaults();
    v32 = !w64; v64 = w64; md_en = 1'b1; md_op = op; ru1 = a; ru2 = b;
    brop = 5'b10000;
    exp_q.push_back(exp);
    @(negedge clk);
    check({name, "_npc_gated"}, {63'h0, w64 ? npc64 : npc32}, 64'h0);
    cnt = 0;
    while (cur_stall(w64) && cnt < 200) begin
      cnt++;
      @(posedge clk); #1;
      ru1 = ~a; ru2 = b ^ 64'h5A; rd_me = 5'd1; ruwr_me = 1'b1; alu_me = ~a;
      rd_wb = 5'd2; ruwr_wb = 1'b1; muxd = ~b;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 64'(cnt), 64'(exp_stall));
    check({name, "_result_valid"}, {63'h0, cur_rv(w64)}, 64'h1);
    e = exp_q.pop_front();
    check({name, "_result"}, cur_out(w64), e);
    v32 = 1'b0; v64 = 1'b0; md_en = 1'b0; brop = 5'd0;
    @(posedge clk); #1;
    set_defaults();
    @(negedge clk);
    check({name, "_rv_drop"}, {63'h0, cur_rv(w64)}, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;

    // ALU and forwarding
    v = base(4'b0000, 5'd0, 32'd5, 32'd0, 32'd10, 1'b0);
    v.rs1 = 5'd3; v.rd_me = 5'd3; v.ruwr_me = 1'b1; v.me = 32'd7;
    v.rd_wb = 5'd3; v.ruwr_wb = 1'b1; v.wb = 32'd9; v.imm = 32'd3; v.bsrc = 1'b1;
    tbl.push_back(v);
    tbl.push_back(base(4'b1000, 5'd0, 32'd5, 32'd8, 32'hFFFF_FFFD, 1'b0));
    tbl.push_back(base(4'b0001, 5'd0, 32'd1, 32'h23, 32'd8, 1'b0));
    tbl.push_back(base(4'b0010, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0));
    tbl.push_back(base(4'b0011, 5'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));
    tbl.push_back(base(4'b0100, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0));
    tbl.push_back(base(4'b0101, 5'd0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0));
    tbl.push_back(base(4'b1101, 5'd0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0));
    tbl.push_back(base(4'b0110, 5'd0, 32'hF0F0_F0F0, 32'h0F00_000F, 32'hFFF0_F0FF, 1'b0));
    tbl.push_back(base(4'b0111, 5'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0));
    v = base(4'b1001, 5'd0, 32'd1, 32'd2, 32'h1234_5678, 1'b0);
    v.bsrc = 1'b1; v.imm = 32'h1234_5678; tbl.push_back(v);
    tbl.push_back(base(4'b1111, 5'd0, 32'd5, 32'd6, 32'd0, 1'b0));
    v = base(4'b0000, 5'd0, 32'd1, 32'd2, 32'h1010, 1'b0);
    v.asrc = 1'b1; v.bsrc = 1'b1; v.imm = 32'h10; tbl.push_back(v);
    v = base(4'b0000, 5'd0, 32'd5, 32'd0, 32'd5, 1'b0);
    v.rs1 = 5'd0; v.rd_me = 5'd0; v.ruwr_me = 1'b1; v.me = 32'h77; tbl.push_back(v);
    v = base(4'b0000, 5'd0, 32'd1, 32'd2, 32'h22, 1'b0);
    v.rs1 = 5'd4; v.rd_wb = 5'd4; v.ruwr_wb = 1'b1; v.wb = 32'h20; tbl.push_back(v);
    v = base(4'b0000, 5'd0, 32'd1, 32'd2, 32'h101, 1'b0);
    v.rs2 = 5'd6; v.rd_me = 5'd6; v.ruwr_me = 1'b1; v.me = 32'h100; tbl.push_back(v);
    // Branches
    v = base(4'b0000, 5'b01100, 32'hFFFF_FFFF, 32'h50, 32'd0, 1'b1);
    v.rs2 = 5'd7; v.rd_wb = 5'd7; v.ruwr_wb = 1'b1; v.wb = 32'd1; tbl.push_back(v);
    v.valid = 1'b0; v.exp_npc = 1'b0; tbl.push_back(v);
    tbl.push_back(base(4'b0000, 5'b01110, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));
    tbl.push_back(base(4'b0000, 5'b01000, 32'd5, 32'd5, 32'd10, 1'b1));
    tbl.push_back(base(4'b0000, 5'b01001, 32'd5, 32'd5, 32'd10, 1'b0));
    tbl.push_back(base(4'b0000, 5'b01101, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));
    tbl.push_back(base(4'b0000, 5'b01111, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1));
    tbl.push_back(base(4'b0000, 5'b10000, 32'd0, 32'd0, 32'd0, 1'b1));
    tbl.push_back(base(4'b0000, 5'b01010, 32'd5, 32'd5, 32'd10, 1'b0));
    tbl.push_back(base(4'b0000, 5'b00100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0));

    // Reset: outputs held quiet even with a live M op and a jump presented
    set_defaults();
    rst = 1'b1; v64 = 1'b1; md_en = 1'b1; brop = 5'b10000;
    @(negedge clk); @(negedge clk);
    check("rst_stall32", {63'h0, stall32}, 64'h0);
    check("rst_rv32", {63'h0, rv32}, 64'h0);
    check("rst_npc32", {63'h0, npc32}, 64'h0);
    check("rst_stall64", {63'h0, stall64}, 64'h0);
    check("rst_npc64", {63'h0, npc64}, 64'h0);
    @(posedge clk); #1;
    set_defaults();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_stall", {63'h0, stall32}, 64'h0);
    check("post_rst_rv", {63'h0, rv32}, 64'h0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      aluop = tbl[i].aluop; brop = tbl[i].brop; v32 = tbl[i].valid;
      asrc = tbl[i].asrc; bsrc = tbl[i].bsrc; rs1 = tbl[i].rs1; rs2 = tbl[i].rs2;
      rd_me = tbl[i].rd_me; rd_wb = tbl[i].rd_wb;
      ruwr_me = tbl[i].ruwr_me; ruwr_wb = tbl[i].ruwr_wb;
      pc = {32'h0, tbl[i].pc}; ru1 = {32'h0, tbl[i].ru1}; ru2 = {32'h0, tbl[i].ru2};
      imm = {32'h0, tbl[i].imm}; alu_me = {32'h0, tbl[i].me}; muxd = {32'h0, tbl[i].wb};
      @(negedge clk);
      check($sformatf("vec%0d_out", i), {32'h0, out32}, {32'h0, tbl[i].exp_out});
      check($sformatf("vec%0d_npc", i), {63'h0, npc32}, {63'h0, tbl[i].exp_npc});
      check($sformatf("vec%0d_stall", i), {63'h0, stall32}, 64'h0);
    end

    // md_en without valid_ex must never start the unit
    @(posedge clk); #1;
    set_defaults();
    v32 = 1'b0; md_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("novalid_stall%0d", k), {63'h0, stall32}, 64'h0);
    end
    @(posedge clk); #1;
    set_defaults();
    ru1 = 64'd2; ru2 = 64'd3;
    @(negedge clk);
    check("novalid_idle_stall", {63'h0, stall32}, 64'h0);
    check("novalid_idle_out", {32'h0, out32}, 64'd5);

    // 32-bit M operations
    md_run(1'b0, 3'b100, 64'h8000_0000, 64'hFFFF_FFFF, 64'h8000_0000, 33, "div_ovf");
    md_run(1'b0, 3'b110, 64'h8000_0000, 64'hFFFF_FFFF, 64'h0, 33, "rem_ovf");
    md_run(1'b0, 3'b101, 64'd100, 64'd0, 64'hFFFF_FFFF, 33, "divu_zero");
    md_run(1'b0, 3'b111, 64'd100, 64'd0, 64'd100, 33, "remu_zero");
    md_run(1'b0, 3'b100, 64'hFFFF_FFFB, 64'd0, 64'hFFFF_FFFF, 33, "div_zero_neg");
    md_run(1'b0, 3'b110, 64'hFFFF_FFFB, 64'd0, 64'hFFFF_FFFB, 33, "rem_zero_neg");
    md_run(1'b0, 3'b001, 64'hFFFF_FFFE, 64'd3, 64'hFFFF_FFFF, 33, "mulh_neg");
    md_run(1'b0, 3'b000, 64'd6, 64'd7, 64'd42, 33, "mul");
    md_run(1'b0, 3'b100, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFD, 33, "div_trunc");
    md_run(1'b0, 3'b110, 64'hFFFF_FFF9, 64'd2, 64'hFFFF_FFFF, 33, "rem_trunc");
    md_run(1'b0, 3'b011, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 33, "mulhu");
    md_run(1'b0, 3'b010, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 33, "mulhsu");
    md_run(1'b0, 3'b101, 64'hFFFF_FFFF, 64'd3, 64'h5555_5555, 33, "divu");

    // Reset in the middle of BUSY aborts without a result
    @(posedge clk); #1;
    set_defaults();
    md_en = 1'b1; md_op = 3'b100; ru1 = 64'd100; ru2 = 64'd7;
    @(negedge clk);
    check("abort_issue_stall", {63'h0, stall32}, 64'h1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1; v32 = 1'b0; md_en = 1'b0;
    @(negedge clk);
    check("abort_rst_stall", {63'h0, stall32}, 64'h0);
    check("abort_rst_rv", {63'h0, rv32}, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_after_stall", {63'h0, stall32}, 64'h0);
    check("abort_after_rv", {63'h0, rv32}, 64'h0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (rv32 || stall32) seen = 1'b1;
    end
    check("abort_no_result", {63'h0, seen}, 64'h0);
    md_run(1'b0, 3'b000, 64'd6, 64'd7, 64'd42, 33, "mul_after_abort");

    // 64-bit instance
    md_run(1'b1, 3'b011, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65, "mulhu64");
    md_run(1'b1, 3'b100, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 65, "div64_ovf");
    md_run(1'b1, 3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, '1, 65, "rem64_trunc");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
